axis_noc_injector: RTL and testbench
====================================

// Module: axis_noc_injector
// PURPOSE
//  Host-to-NoC ingress: accepts one AXI-Stream slave and steers whole packets onto NUM_CH NoC injection
//  ports, replacing the single-port passthrough at mesh node [0][0]. Channel is chosen from tdest on first
//  beat and locked until tlast. Per-channel FIFOs decouple host bursts from mesh backpressure; packets with
//  an out-of-range channel are dropped and counted.
// PARAMETERS
//  DATAW   512  tdata width
//  USERW   75   tuser width
//  DESTW   12   tdest width
//  NUM_CH  4    injection channels (1..16)
//  FIFOD   16   per-channel FIFO depth (power of 2, >=2)
//  CHW     localparam = (NUM_CH>1) ? $clog2(NUM_CH) : 1
// PORTS
//  clk            in   1            single clock
//  rst            in   1            synchronous, active-high reset
//  s_axis_tvalid  in   1            host beat valid
//  s_axis_tready  out  1            host beat accepted
//  s_axis_tdata   in   DATAW        host payload
//  s_axis_tlast   in   1            last beat of packet
//  s_axis_tuser   in   USERW        sideband, forwarded unchanged
//  s_axis_tdest   in   DESTW        NoC destination; [CHW-1:0] selects channel
//  m_axis_tvalid  out  [NUM_CH]     per-channel valid
//  m_axis_tready  in   [NUM_CH]     per-channel ready from mesh
//  m_axis_tdata   out  [NUM_CH][DATAW]  payload
//  m_axis_tlast   out  [NUM_CH]     last
//  m_axis_tuser   out  [NUM_CH][USERW]  sideband
//  m_axis_tdest   out  [NUM_CH][DESTW]  tdest, unchanged
//  drop_cnt       out  32           packets dropped, saturating
// BEHAVIOUR
//  Reset: FSM=IDLE, all FIFOs empty, m_axis_tvalid=0, s_axis_tready=0 during rst, drop_cnt=0.
//  Data outputs (tdata/tuser/tdest/tlast) are don't-care while tvalid=0.
//  FSM states IDLE, FWD, DROP (held in shared package enum):
//   IDLE: ch = s_axis_tdest[CHW-1:0] (0 if NUM_CH==1). On handshake with ch<NUM_CH: write beat to FIFO[ch],
//         latch ch_q; tlast=1 -> stay IDLE, else -> FWD. With ch>=NUM_CH: discard beat, tlast=1 -> IDLE
//         and drop_cnt++, else -> DROP.
//   FWD:  all beats go to FIFO[ch_q] regardless of their tdest; on tlast handshake -> IDLE.
//   DROP: s_axis_tready=1; beats discarded; on tlast handshake drop_cnt++ (saturate at 2^32-1) -> IDLE.
//  s_axis_tready: IDLE -> !full[ch of current tdest] (1 if out of range); FWD -> !full[ch_q]; DROP -> 1.
//   tready is combinational on tdest in IDLE only; never depends on s_axis_tvalid.
//  FIFO: write latency 1 -- beat accepted in cycle N is visible on m_axis_* in cycle N+1 at earliest.
//   Pop on m_axis_tvalid & m_axis_tready. Simultaneous push/pop at any occupancy (incl. full-1 and 1)
//   legal; at full, push blocked by tready (pop in same cycle does not re-open tready that cycle).
//   Pointers wrap modulo FIFOD; count is CLOG2(FIFOD)+1 bits, full at count==FIFOD.
//  Once m_axis_tvalid[c]=1, it and its data hold until m_axis_tready[c] (AXIS stability).
//  Channels independent: stall on channel c never blocks pops on others; only host input stalls.
//  Beat order within a channel preserved; packets never interleave on a channel.
//  Reset mid-packet: partial packet in FIFOs flushed, FSM -> IDLE; next host beat treated as first beat.
//  drop_cnt unaffected by backpressure; not cleared except by rst.
// STRUCTURE
//  Shared package noc_pkg: inj_state_t {IDLE,FWD,DROP}, typedef axis_beat_t packed {tlast,tuser,tdest,tdata}
//   (widths from package DATAW/USERW/DESTW).
//  Sub-module axis_sync_fifo #(WIDTH,DEPTH): one per channel via generate; registered output, count-based
//  full/empty. Top holds FSM, channel decode, tready mux, drop counter.
// TESTING
//  1 single-beat packets tdest=0,1,2,3 (NUM_CH=4), all m_tready=1 -> each appears on its channel 1 cycle later.
//  2 8-beat packet tdest=0x002, later beats tdest=0x001 -> all 8 beats on ch2, tlast only on beat 8.
//  3 NUM_CH=3, packet tdest=3 of 5 beats -> tready=1 throughout, no m_tvalid, drop_cnt 0->1.
//  4 m_tready[1]=0, stream 20 beats to ch1 (FIFOD=16) -> tready drops after beat 16; ch0 traffic still drains
//    after ch1 packet completes; release -> all 20 beats, in order, no loss.
//  5 random valid/ready on 4 channels, 10k packets -> scoreboard per-channel order, no interleave, no dup.
//  6 assert rst mid-packet (beat 3 of 6) -> next cycle all m_tvalid=0, drop_cnt=0; new packet routes normally.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared types for the host-to-NoC injector: FSM state encoding and the beat layout
// carried through the per-channel FIFOs.
package noc_pkg;

   localparam int DATAW = 512;
   localparam int USERW = 75;
   localparam int DESTW = 12;

   typedef enum logic [1:0] {
      IDLE,
      FWD,
      DROP
   } inj_state_t;

   typedef struct packed {
      logic             tlast;
      logic [USERW-1:0] tuser;
      logic [DESTW-1:0] tdest;
      logic [DATAW-1:0] tdata;
   } axis_beat_t;

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with a registered first-word output; a write into an empty FIFO
// lands directly in the output register so it is visible one cycle after the push.
module axis_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_din,
   output logic             o_full,
   output logic             o_valid,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_dout
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_valid;
   logic [WIDTH-1:0] r_dout;

   logic [CW-1:0]    w_mem_cnt;
   logic             w_mem_empty;
   logic             w_pop;
   logic             w_bypass;
   logic             w_mem_wr;
   logic             w_mem_rd;

   // r_count covers the output register plus the array entries behind it
   assign w_mem_cnt   = r_count - CW'(r_valid);
   assign w_mem_empty = (w_mem_cnt == '0);
   assign w_pop       = r_valid & i_rd_en;
   assign w_bypass    = i_wr_en & w_mem_empty & (~r_valid | w_pop);
   assign w_mem_wr    = i_wr_en & ~w_bypass;
   assign w_mem_rd    = w_pop & ~w_mem_empty;

   always_ff @(posedge clk) begin
      if (srst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_count <= r_count + CW'(i_wr_en) - CW'(w_pop);
         if (w_mem_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_mem_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_bypass | w_mem_rd) r_valid <= 1'b1;
         else if (w_pop)          r_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_wr) r_mem[r_wr_ptr] <= i_din;
      if (w_bypass)      r_dout <= i_din;
      else if (w_mem_rd) r_dout <= r_mem[r_rd_ptr];
   end

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_valid = r_valid;
   assign o_dout  = r_dout;

endmodule

// File: rtl/axis_noc_injector.sv
// Host AXI-Stream ingress that steers whole packets onto NUM_CH NoC injection ports,
// locking the channel from the first beat's tdest and dropping out-of-range packets.
module axis_noc_injector
   import noc_pkg::*;
#(
   parameter int DATAW  = noc_pkg::DATAW,
   parameter int USERW  = noc_pkg::USERW,
   parameter int DESTW  = noc_pkg::DESTW,
   parameter int NUM_CH = 4,
   parameter int FIFOD  = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           s_axis_tvalid,
   output logic                           s_axis_tready,
   input  logic [DATAW-1:0]               s_axis_tdata,
   input  logic                           s_axis_tlast,
   input  logic [USERW-1:0]               s_axis_tuser,
   input  logic [DESTW-1:0]               s_axis_tdest,
   output logic [NUM_CH-1:0]              m_axis_tvalid,
   input  logic [NUM_CH-1:0]              m_axis_tready,
   output logic [NUM_CH-1:0][DATAW-1:0]   m_axis_tdata,
   output logic [NUM_CH-1:0]              m_axis_tlast,
   output logic [NUM_CH-1:0][USERW-1:0]   m_axis_tuser,
   output logic [NUM_CH-1:0][DESTW-1:0]   m_axis_tdest,
   output logic [31:0]                    drop_cnt
);
   localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int NPAD  = 1 << CHW;
   localparam int BEATW = 1 + USERW + DESTW + DATAW;

   inj_state_t        r_state;
   inj_state_t        w_state_next;
   logic [CHW-1:0]    r_ch;
   logic [CHW-1:0]    w_ch_in;
   logic [CHW-1:0]    w_ch_sel;
   logic              w_in_range;
   logic              w_fire;
   logic              w_push_ok;
   logic              w_drop_done;
   logic [NUM_CH-1:0] w_full_ch;
   logic [NPAD-1:0]   w_full;
   logic [NUM_CH-1:0] w_push;
   logic [BEATW-1:0]  w_beat_in;
   logic [31:0]       r_drop_cnt;

   generate
      if (NUM_CH > 1) begin : g_multi_ch
         assign w_ch_in    = s_axis_tdest[CHW-1:0];
         assign w_in_range = (32'(w_ch_in) < NUM_CH);
      end else begin : g_single_ch
         assign w_ch_in    = '0;
         assign w_in_range = 1'b1;
      end
   endgenerate

   // Padding lets the tready mux index any decoded channel, even an unused one
   assign w_full    = NPAD'(w_full_ch);
   assign w_fire    = s_axis_tvalid & s_axis_tready;
   assign w_beat_in = {s_axis_tlast, s_axis_tuser, s_axis_tdest, s_axis_tdata};

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:     if (w_fire && !s_axis_tlast) w_state_next = w_in_range ? FWD : DROP;
         FWD,
         DROP:     if (w_fire && s_axis_tlast)  w_state_next = IDLE;
         default:  w_state_next = IDLE;
      endcase
   end

   always_comb begin
      s_axis_tready = 1'b0;
      w_ch_sel      = r_ch;
      w_push_ok     = 1'b0;
      w_drop_done   = 1'b0;
      if (!rst) begin
         case (r_state)
            IDLE: begin
               w_ch_sel      = w_ch_in;
               s_axis_tready = w_in_range ? ~w_full[w_ch_in] : 1'b1;
               w_push_ok     = w_in_range;
               w_drop_done   = ~w_in_range & s_axis_tlast;
            end
            FWD: begin
               s_axis_tready = ~w_full[r_ch];
               w_push_ok     = 1'b1;
            end
            DROP: begin
               s_axis_tready = 1'b1;
               w_drop_done   = s_axis_tlast;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ch       <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (r_state == IDLE && w_fire && w_in_range) r_ch <= w_ch_in;
         if (w_fire && w_drop_done && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 32'd1;
      end
   end

   assign drop_cnt = r_drop_cnt;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [BEATW-1:0] w_dout;

         assign w_push[gi] = w_fire & w_push_ok & (w_ch_sel == CHW'(gi));

         axis_sync_fifo #(
            .WIDTH (BEATW),
            .DEPTH (FIFOD)
         ) u_fifo (
            .clk     (clk),
            .srst    (rst),
            .i_wr_en (w_push[gi]),
            .i_din   (w_beat_in),
            .o_full  (w_full_ch[gi]),
            .o_valid (m_axis_tvalid[gi]),
            .i_rd_en (m_axis_tready[gi]),
            .o_dout  (w_dout)
         );

         assign {m_axis_tlast[gi], m_axis_tuser[gi], m_axis_tdest[gi], m_axis_tdata[gi]} = w_dout;
      end
   endgenerate

endmodule

// File: tb/tb_axis_noc_injector.sv
// Randomised bench for axis_noc_injector (3 channels, so tdest[1:0]==3 exercises drops)
// against a packet-level reference: per-channel expected beat queues and a drop tally.
module tb_axis_noc_injector;
   localparam int DW  = 32;
   localparam int UW  = 8;
   localparam int TW  = 12;
   localparam int NCH = 3;
   localparam int FD  = 16;
   localparam int BW  = 1 + UW + TW + DW;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  s_tvalid;
   logic                  s_tready;
   logic [DW-1:0]         s_tdata;
   logic                  s_tlast;
   logic [UW-1:0]         s_tuser;
   logic [TW-1:0]         s_tdest;
   logic [NCH-1:0]        m_tvalid;
   logic [NCH-1:0]        m_tready;
   logic [NCH-1:0][DW-1:0] m_tdata;
   logic [NCH-1:0]        m_tlast;
   logic [NCH-1:0][UW-1:0] m_tuser;
   logic [NCH-1:0][TW-1:0] m_tdest;
   logic [31:0]           drop_cnt;

   int             n_cmp = 0;
   int             n_bad = 0;
   logic [BW-1:0]  exp_q [NCH][$];
   int             exp_drop = 0;
   int             acc_cnt = 0;
   int             cyc = 0;
   bit             rand_ready = 1'b0;
   logic [NCH-1:0] ready_fix = '1;
   logic [BW-1:0]  last_beat;

   always #5 clk = ~clk;

   axis_noc_injector #(
      .DATAW (DW), .USERW (UW), .DESTW (TW), .NUM_CH (NCH), .FIFOD (FD)
   ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tdata  (s_tdata),
      .s_axis_tlast  (s_tlast),
      .s_axis_tuser  (s_tuser),
      .s_axis_tdest  (s_tdest),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tlast  (m_tlast),
      .m_axis_tuser  (m_tuser),
      .m_axis_tdest  (m_tdest),
      .drop_cnt      (drop_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial m_tready = '1;
   always @(posedge clk) begin
      cyc++;
      #1;
      m_tready = rand_ready ? NCH'($urandom) : ready_fix;
   end

   // Output monitor: pops are checked against the model; stalled beats must hold steady
   logic [NCH-1:0] hold = '0;
   logic [BW-1:0]  hold_beat [NCH];
   logic [BW-1:0]  mb;
   always @(negedge clk) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) exp_q[c].delete();
         hold = '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            mb = {m_tlast[c], m_tuser[c], m_tdest[c], m_tdata[c]};
            if (hold[c]) begin
               check($sformatf("hold_valid_ch%0d", c), 64'(m_tvalid[c]), 64'd1);
               if (m_tvalid[c]) check($sformatf("hold_data_ch%0d", c), 64'(mb), 64'(hold_beat[c]));
            end
            if (m_tvalid[c] && m_tready[c]) begin
               if (exp_q[c].size() == 0) check($sformatf("unexpected_beat_ch%0d", c), 64'd1, 64'd0);
               else check($sformatf("beat_ch%0d", c), 64'(mb), 64'(exp_q[c].pop_front()));
            end
            hold[c]      = m_tvalid[c] & ~m_tready[c];
            hold_beat[c] = mb;
         end
      end
   end

   // Drive one packet; the model routes it by the first beat's tdest[1:0]
   task automatic send_pkt(input int len, input logic [TW-1:0] dest0, input int later,
                           input int stop_after, input bit gaps);
      logic [1:0] ch;
      bit         drop;
      bit         ok;
      ch   = dest0[1:0];
      drop = (int'(ch) >= NCH);
      for (int i = 0; i < len && i < stop_after; i++) begin
         if (gaps && $urandom_range(3, 0) == 0) begin
            s_tvalid = 1'b0;
            @(posedge clk); #1;
         end
         s_tvalid = 1'b1;
         s_tdata  = $urandom;
         s_tuser  = UW'($urandom);
         s_tdest  = (i == 0) ? dest0 : ((later < 0) ? TW'($urandom) : TW'(later));
         s_tlast  = (i == len - 1);
         ok = 1'b0;
         for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            if (s_tready) begin
               ok = 1'b1;
               acc_cnt++;
               last_beat = {s_tlast, s_tuser, s_tdest, s_tdata};
               if (!drop) exp_q[ch].push_back(last_beat);
               else if (s_tlast) exp_drop++;
            end
            @(posedge clk); #1;
         end
         if (!ok) begin
            check("accept_timeout", 64'd0, 64'd1);
            s_tvalid = 1'b0;
            return;
         end
      end
      s_tvalid = 1'b0;
   endtask

   function automatic int pending();
      int n = 0;
      for (int c = 0; c < NCH; c++) n += exp_q[c].size();
      return n;
   endfunction

   task automatic drain(input string tag);
      for (int t = 0; t < 400 && pending() > 0; t++) @(posedge clk);
      #1;
      check(tag, 64'(pending()), 64'd0);
   endtask

   initial begin
      int acc0;
      int t0;
      rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tuser = '0; s_tdest = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tready", 64'(s_tready), 64'd0);
      check("rst_mvalid", 64'(m_tvalid), 64'd0);
      check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // single-beat packets appear on their channel one cycle after acceptance
      for (int c = 0; c < NCH; c++) begin
         send_pkt(1, TW'(c), -1, 99, 1'b0);
         check($sformatf("lat_valid_ch%0d", c), 64'(m_tvalid), 64'(1 << c));
         check($sformatf("lat_data_ch%0d", c),
               64'({m_tlast[c], m_tuser[c], m_tdest[c], m_tdata[c]}), 64'(last_beat));
      end
      drain("single_drain");

      // 8-beat packet locked to ch2 although later beats point at ch1
      send_pkt(8, 12'h002, 1, 99, 1'b0);
      drain("lock_drain");

      // out-of-range packet: accepted every cycle, nothing emitted, counted once
      check("drop_before", 64'(drop_cnt), 64'd0);
      t0 = cyc;
      send_pkt(5, 12'h003, -1, 99, 1'b0);
      check("drop_cycles", 64'(cyc - t0), 64'd5);
      check("drop_after", 64'(drop_cnt), 64'd1);
      repeat (4) @(posedge clk); #1;
      check("drop_no_mvalid", 64'(m_tvalid), 64'd0);

      // backpressure: ch1 fills at FD beats while stalled ch0 still drains independently
      ready_fix = 3'b110;
      send_pkt(4, 12'h000, -1, 99, 1'b0);
      ready_fix = 3'b100;
      acc0 = acc_cnt;
      fork
         send_pkt(20, 12'h001, -1, 99, 1'b0);
         begin
            repeat (40) @(negedge clk);
            check("bp_accepted", 64'(acc_cnt - acc0), 64'(FD));
            check("bp_tready", 64'(s_tready), 64'd0);
            ready_fix = 3'b101;
            repeat (10) @(negedge clk);
            check("bp_ch0_drained", 64'(exp_q[0].size()), 64'd0);
            check("bp_ch1_held", 64'(m_tvalid[1]), 64'd1);
            ready_fix = 3'b111;
         end
      join
      drain("bp_drain");

      // reset during beat 3 of a 6-beat packet
      ready_fix = 3'b110;
      send_pkt(6, 12'h000, -1, 3, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_tready", 64'(s_tready), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_drop = 0;
      ready_fix = 3'b111;
      @(negedge clk);
      check("mid_rst_mvalid", 64'(m_tvalid), 64'd0);
      check("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
      @(posedge clk); #1;
      send_pkt(3, 12'h001, -1, 99, 1'b0);
      drain("post_rst_drain");

      // randomised traffic with random per-channel backpressure
      rand_ready = 1'b1;
      for (int p = 0; p < 1500; p++)
         send_pkt($urandom_range(8, 1), TW'($urandom), -1, 99, 1'b1);
      rand_ready = 1'b0;
      ready_fix  = '1;
      drain("rand_drain");
      check("rand_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
      repeat (2) @(posedge clk); #1;
      check("final_mvalid", 64'(m_tvalid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
